// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the "001" detector sequencer:
//   sched_state_e : scheduler FSM states (IDLE, CLEAR, SHIFT, DRAIN, RESP)
//   det_state_e   : detector core states (S0 idle, S1 seen 0, S2 seen 00,
//                   S3 seen 001)
//   REQ0 / REQ1   : requester id values carried on rsp_id
// No ports (package).
// ---------------------------------------------------------------------------
package seq_det_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    RESP
  } sched_state_e;

  typedef enum logic [1:0] {
    S0,
    S1,
    S2,
    S3
  } det_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/det001_core.sv
// ---------------------------------------------------------------------------
// det001_core
// Serial Moore detector for the pattern "001". det is high for one cycle
// after the bit that completes the pattern has been clocked in.
// Ports:
//   clk   : clock, state updates on rising edge
//   reset : synchronous active-high reset, returns the detector to S0
//   inp   : serial input bit
//   det   : high while in S3 (pattern just seen)
// ---------------------------------------------------------------------------
module det001_core
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inp,
  output logic det
);

  det_state_e state_q;
  det_state_e state_d;

  // State register; reset also serves as the per-job clear from the sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Transition table. "001" cannot overlap itself, so from S3 a 0 only
  // counts as the first zero of a fresh pattern.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S0:      state_d = inp ? S0 : S1;
      S1:      state_d = inp ? S0 : S2;
      S2:      state_d = inp ? S3 : S2;
      S3:      state_d = inp ? S0 : S1;
      default: state_d = S0;
    endcase
  end

  assign det = (state_q == S3);

endmodule

// File: rtl/seq_det_sched.sv
// ---------------------------------------------------------------------------
// seq_det_sched
// Sequencer that shares one "001" detector between two requesters. A word
// is accepted over a valid/ready handshake (round-robin when both ask),
// shifted MSB-first into the detector, hits are counted, and the count is
// returned with the requester id over a response handshake.
// Ports:
//   clk        : clock
//   reset      : synchronous active-high reset, aborts any job in flight
//   req_valid  : per-requester word valid
//   req_data0  : word from requester 0
//   req_data1  : word from requester 1
//   req_ready  : one-hot acceptance, only ever high in IDLE
//   rsp_valid  : result available (RESP state)
//   rsp_ready  : consumer takes the result
//   rsp_id     : requester owning the result
//   rsp_count  : number of "001" occurrences in the word
//   busy       : high in every state except IDLE
// ---------------------------------------------------------------------------
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [CW-1:0]    rsp_count,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);

  sched_state_e     state_q, state_d;
  logic             rr_q, rr_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;

  logic grant_vld;
  logic grant_id;
  logic clear;
  logic det_in;
  logic det;

  // The detector is cleared by system reset and by the one-cycle CLEAR
  // strobe, so every job starts from S0 regardless of the previous word.
  det001_core u_det (
    .clk   (clk),
    .reset (reset | clear),
    .inp   (det_in),
    .det   (det)
  );

  // Grant selection: a lone requester always wins, a tie goes to the
  // requester named by the round-robin pointer.
  always_comb begin
    grant_vld = |req_valid;
    case (req_valid)
      2'b01:   grant_id = REQ0;
      2'b10:   grant_id = REQ1;
      2'b11:   grant_id = rr_q;
      default: grant_id = REQ0;
    endcase
  end

  // Job register bank; reset discards any job in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= REQ0;
      shreg_q  <= '0;
      id_q     <= REQ0;
      cnt_q    <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      shreg_q  <= shreg_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Next-state and output logic. det is a Moore output that lags its bit by
  // one cycle, so counting runs through SHIFT and the extra DRAIN cycle;
  // the first SHIFT cycle sees det=0 because CLEAR just reset the detector.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    shreg_d   = shreg_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    clear     = 1'b0;
    det_in    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_vld && !reset) begin
          req_ready = grant_id ? 2'b10 : 2'b01;
          shreg_d   = grant_id ? req_data1 : req_data0;
          id_d      = grant_id;
          cnt_d     = '0;
          bitcnt_d  = '0;
          state_d   = CLEAR;
        end
      end

      CLEAR: begin
        clear   = 1'b1;
        state_d = SHIFT;
      end

      SHIFT: begin
        det_in   = shreg_q[WIDTH-1];
        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
        bitcnt_d = bitcnt_q + BW'(1);
        if (det) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (bitcnt_q == BW'(WIDTH - 1)) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        det_in = 1'b0;
        if (det) begin
          cnt_d = cnt_q + CW'(1);
        end
        state_d = RESP;
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rr_d    = ~id_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rsp_id    = id_q;
  assign rsp_count = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_det_sched.sv
// ---------------------------------------------------------------------------
// tb_seq_det_sched
// Directed self-checking bench for seq_det_sched (WIDTH=8). Inputs change
// and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_seq_det_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [7:0] req_data0 = 8'h00;
  logic [7:0] req_data1 = 8'h00;
  logic [1:0] req_ready;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_id;
  logic [3:0] rsp_count;
  logic       busy;

  int total = 0;
  int bad   = 0;

  seq_det_sched #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Hard stop in case some wait below never returns
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reset held two edges, then twenty idle cycles with nothing requested
  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, rsp_valid, req_ready, rsp_count, rsp_id} !== 9'b0) begin
      bad++;
      $display("[TB] FAIL reset_hold: got %b expected %b",
               {busy, rsp_valid, req_ready, rsp_count, rsp_id}, 9'b0);
    end
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if ({busy, rsp_valid, req_ready, rsp_count} !== 8'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle cycle %0d: got %b expected %b", c,
                 {busy, rsp_valid, req_ready, rsp_count}, 8'b0);
      end
    end
  endtask

  // One complete job from a lone requester with rsp_ready high. Acceptance
  // is edge 1; rsp_valid must be visible after edge 11 and not before, and
  // the block is idle again after the following edge.
  task automatic test_job(input logic id, input logic [7:0] data,
                          input logic [3:0] expCount, input string name);
    logic [1:0] expReady;
    logic       early;
    expReady  = id ? 2'b10 : 2'b01;
    early     = 1'b0;
    @(negedge clk);
    req_data0 = id ? 8'h00 : data;
    req_data1 = id ? data : 8'h00;
    req_valid = expReady;
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== expReady) begin
      bad++;
      $display("[TB] FAIL %s_ready: got %b expected %b", name, req_ready, expReady);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    total++;
    if ({busy, req_ready} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL %s_clear: got %b expected %b", name, {busy, req_ready}, 3'b100);
    end
    for (int e = 2; e <= 10; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) early = 1'b1;
    end
    total++;
    if (early !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_early_rsp: got %b expected %b", name, early, 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, id, expCount}) begin
      bad++;
      $display("[TB] FAIL %s_rsp: got %b expected %b", name,
               {rsp_valid, rsp_id, rsp_count}, {1'b1, id, expCount});
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, rsp_valid} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL %s_idle: got %b expected %b", name, {busy, rsp_valid}, 2'b00);
    end
  endtask

  // "001" at bits 7..5 and 4..2 -> 2
  task automatic test_single_req0();
    test_job(1'b0, 8'b0010_0100, 4'd2, "req0_24");
  endtask

  task automatic test_req1_patterns();
    test_job(1'b1, 8'b0000_0001, 4'd1, "req1_01");
    test_job(1'b1, 8'b1111_1111, 4'd0, "req1_ff");
    test_job(1'b1, 8'b0010_0101, 4'd2, "req1_25");
  endtask

  // Both requesters always valid: grants alternate 0,1,0,1 from reset and
  // never appear while busy. Requester 0 carries 0x24 (2 hits), requester 1
  // carries 0x01 (1 hit).
  task automatic test_back_to_back();
    int         grants;
    int         rsps;
    logic       busyGrant;
    logic [1:0] expReady;
    logic       expId;
    logic [3:0] expCount;
    grants    = 0;
    rsps      = 0;
    busyGrant = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    req_data0 = 8'b0010_0100;
    req_data1 = 8'b0000_0001;
    req_valid = 2'b11;
    for (int c = 0; c < 80 && rsps < 4; c++) begin
      #1;
      if (req_ready !== 2'b00) begin
        expReady = (grants % 2 == 0) ? 2'b01 : 2'b10;
        total++;
        if (req_ready !== expReady) begin
          bad++;
          $display("[TB] FAIL rr_grant %0d: got %b expected %b", grants, req_ready, expReady);
        end
        if (busy) busyGrant = 1'b1;
        grants++;
      end
      if (rsp_valid) begin
        expId    = (rsps % 2 == 1);
        expCount = expId ? 4'd1 : 4'd2;
        total++;
        if ({rsp_id, rsp_count} !== {expId, expCount}) begin
          bad++;
          $display("[TB] FAIL rr_rsp %0d: got %b expected %b", rsps,
                   {rsp_id, rsp_count}, {expId, expCount});
        end
        rsps++;
        if (rsps == 4) req_valid = 2'b00;
      end
      @(negedge clk);
    end
    total++;
    if (rsps !== 4) begin
      bad++;
      $display("[TB] FAIL rr_rsp_total: got %0d expected %0d", rsps, 4);
    end
    total++;
    if (grants !== 4) begin
      bad++;
      $display("[TB] FAIL rr_grant_total: got %0d expected %0d", grants, 4);
    end
    total++;
    if (busyGrant !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rr_grant_while_busy: got %b expected %b", busyGrant, 1'b0);
    end
  endtask

  // Result held for five cycles with rsp_ready low while requester 0 keeps
  // a second word pending; that word is granted only once RESP completes.
  task automatic test_backpressure();
    logic got;
    got = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_data0 = 8'b0010_0100;
    req_valid = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("[TB] FAIL bp_accept: got %b expected %b", req_ready, 2'b01);
    end
    @(negedge clk);
    for (int c = 0; c < 20 && !got; c++) begin
      if (rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_rsp_timeout: got %b expected %b", got, 1'b1);
      req_valid = 2'b00;
      return;
    end
    for (int c = 0; c < 5; c++) begin
      total++;
      if ({rsp_valid, rsp_id, rsp_count, req_ready} !== {1'b1, 1'b0, 4'd2, 2'b00}) begin
        bad++;
        $display("[TB] FAIL bp_hold %0d: got %b expected %b", c,
                 {rsp_valid, rsp_id, rsp_count, req_ready}, {1'b1, 1'b0, 4'd2, 2'b00});
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if ({rsp_valid, req_ready} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL bp_release: got %b expected %b", {rsp_valid, req_ready}, 3'b100);
    end
    @(negedge clk);
    total++;
    if ({busy, rsp_valid, req_ready} !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL bp_pending_grant: got %b expected %b",
               {busy, rsp_valid, req_ready}, 4'b0001);
    end
    @(negedge clk);
    req_valid = 2'b00;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_pending_busy: got %b expected %b", busy, 1'b1);
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (!busy) got = 1'b1;
    end
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_second_job_timeout: got %b expected %b", got, 1'b1);
    end
  endtask

  // Reset during the 4th SHIFT cycle drops the job silently; a fresh job
  // afterwards must still count correctly from a cleared detector.
  task automatic test_reset_mid_job();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_data0 = 8'b0010_0100;
    req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, rsp_valid} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL abort_in_shift: got %b expected %b", {busy, rsp_valid}, 2'b10);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({busy, rsp_valid, req_ready, rsp_count} !== 8'b0) begin
      bad++;
      $display("[TB] FAIL abort_idle: got %b expected %b",
               {busy, rsp_valid, req_ready, rsp_count}, 8'b0);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_no_rsp: got %b expected %b", seen, 1'b0);
    end
    test_job(1'b0, 8'b0010_0100, 4'd2, "post_abort");
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_req1_patterns();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
